// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - Wishbone classic slave: prescaled 32-bit up-counter with compare match interrupt
`timescale 1ns/1ps

module wb_timer #(
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic        i_clk,
   input  logic        i_arst_n,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [3:0]  i_wb_sel,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   output logic [31:0] o_wb_dat,
   output logic        o_wb_ack,
   output logic        o_int
);

   localparam logic [1:0] ADR_CTRL    = 2'd0;
   localparam logic [1:0] ADR_COUNT   = 2'd1;
   localparam logic [1:0] ADR_COMPARE = 2'd2;
   localparam logic [1:0] ADR_STATUS  = 2'd3;

   logic                      access;
   logic                      wr_en;
   logic                      rd_en;
   logic [1:0]                reg_sel;
   logic                      unused_adr;

   logic                      ctrl_en;
   logic                      ctrl_auto_reload;
   logic                      ctrl_ie;
   logic [PRESCALE_WIDTH-1:0] ctrl_prescale;
   logic [PRESCALE_WIDTH-1:0] presc_cnt;
   logic [31:0]               count;
   logic [31:0]               compare;
   logic                      match;

   logic                      tick;
   logic                      hit;
   logic [2:0]                ctrl_flags_next;
   logic [PRESCALE_WIDTH-1:0] ctrl_prescale_next;
   logic [PRESCALE_WIDTH-1:0] presc_cnt_next;
   logic [31:0]               count_next;
   logic [31:0]               compare_next;
   logic                      match_next;
   logic [31:0]               rd_data;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   // The ack register itself blocks a second access on the cycle it is high.
   always_comb begin
      access  = i_wb_cyc & i_wb_stb & ~o_wb_ack;
      wr_en   = access & i_wb_we;
      rd_en   = access & ~i_wb_we;
      reg_sel = i_wb_adr[3:2];
   end

   assign unused_adr = ^{i_wb_adr[31:4], i_wb_adr[1:0]};

   always_comb begin
      tick           = ctrl_en && (presc_cnt == ctrl_prescale);
      hit            = tick && (count == compare);
      presc_cnt_next = (ctrl_en && !tick) ? presc_cnt + 1'b1 : '0;
   end

   // Bus writes are merged on top of the timer update so the bus wins per lane.
   always_comb begin
      count_next = count;
      if (tick) count_next = (hit && ctrl_auto_reload) ? 32'd0 : count + 32'd1;
      if (wr_en && reg_sel == ADR_COUNT) count_next = lane_merge(count_next, i_wb_dat, i_wb_sel);

      compare_next = compare;
      if (wr_en && reg_sel == ADR_COMPARE) compare_next = lane_merge(compare, i_wb_dat, i_wb_sel);

      match_next = match;
      if (wr_en && reg_sel == ADR_STATUS && i_wb_sel[0] && i_wb_dat[0]) match_next = 1'b0;
      if (hit) match_next = 1'b1;
   end

   always_comb begin
      ctrl_flags_next    = {ctrl_ie, ctrl_auto_reload, ctrl_en};
      ctrl_prescale_next = ctrl_prescale;
      if (wr_en && reg_sel == ADR_CTRL) begin
         if (i_wb_sel[0]) ctrl_flags_next = i_wb_dat[2:0];
         for (int i = 0; i < PRESCALE_WIDTH; i++) begin
            if (i_wb_sel[2 + i/8]) ctrl_prescale_next[i] = i_wb_dat[16 + i];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (reg_sel)
         ADR_CTRL: begin
            rd_data[2:0]                    = {ctrl_ie, ctrl_auto_reload, ctrl_en};
            rd_data[16 +: PRESCALE_WIDTH]   = ctrl_prescale;
         end
         ADR_COUNT:   rd_data = count;
         ADR_COMPARE: rd_data = compare;
         ADR_STATUS:  rd_data[0] = match;
         default:     rd_data = '0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         o_wb_ack         <= 1'b0;
         o_wb_dat         <= '0;
         ctrl_en          <= 1'b0;
         ctrl_auto_reload <= 1'b0;
         ctrl_ie          <= 1'b0;
         ctrl_prescale    <= '0;
         presc_cnt        <= '0;
         count            <= '0;
         compare          <= 32'hFFFF_FFFF;
         match            <= 1'b0;
      end else begin
         o_wb_ack         <= access;
         o_wb_dat         <= rd_en ? rd_data : 32'd0;
         {ctrl_ie, ctrl_auto_reload, ctrl_en} <= ctrl_flags_next;
         ctrl_prescale    <= ctrl_prescale_next;
         presc_cnt        <= presc_cnt_next;
         count            <= count_next;
         compare          <= compare_next;
         match            <= match_next;
      end
   end

   assign o_int = match & ctrl_ie;

endmodule
